// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide each retire one bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept time.
// Optional feature: define MDU_FAST_MUL_EN to replace the iterative multiplier
// with a single-cycle combinational product (divide path unchanged).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     M-extension instruction present in EX, held until resp_valid
//   req_op        funct3 (0 MUL .. 7 REMU)
//   req_op1/2     forwarded rs1/rs2
//   flush         kill any in-flight operation
//   busy          stall request (combinational: req_valid & !resp_valid)
//   resp_valid    one-cycle result strobe
//   resp_data     result
module ex_mdu #(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0]     r_op2, w_op2_nxt;
  logic [2:0]          r_op, w_op_nxt;
  logic                r_neg_q, w_neg_q_nxt;
  logic                r_neg_r, w_neg_r_nxt;
  logic                r_resp_valid, w_resp_valid_nxt;
  logic [XLEN-1:0]     r_resp_data, w_resp_data_nxt;

  // Request decode: which operands are signed, their magnitudes, special cases.
  logic                w_op1_signed, w_op2_signed;
  logic                w_n1, w_n2;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic                w_div0, w_ovf;

  assign w_op1_signed = (req_op == 3'd1) || (req_op == 3'd2) ||
                        (req_op == 3'd4) || (req_op == 3'd6);
  assign w_op2_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
  assign w_n1   = w_op1_signed & req_op1[XLEN-1];
  assign w_n2   = w_op2_signed & req_op2[XLEN-1];
  assign w_mag1 = w_n1 ? -req_op1 : req_op1;
  assign w_mag2 = w_n2 ? -req_op2 : req_op2;
  assign w_div0 = (req_op2 == '0);
  assign w_ovf  = !req_op[0] && (req_op1 == MIN_NEG) && (req_op2 == '1);

  // Multiply step: acc = {hi, multiplier}; add multiplicand to hi on lsb, shift right.
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op2} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  logic [XLEN:0]       w_div_rem, w_div_diff;
  logic                w_div_ge;
  logic [2*XLEN-1:0]   w_div_acc;
  assign w_div_rem  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge   = (w_div_rem >= {1'b0, r_op2});
  assign w_div_diff = w_div_rem - {1'b0, r_op2};
  assign w_div_acc  = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_rem[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_div_ge};

`ifdef MDU_FAST_MUL_EN
  // One extra sign/zero bit per operand makes every multiply flavour a signed product.
  logic [XLEN:0]              w_x1, w_x2;
  logic signed [2*XLEN+1:0]   w_fast_full;
  assign w_x1 = {w_op1_signed & req_op1[XLEN-1], req_op1};
  assign w_x2 = {w_op2_signed & req_op2[XLEN-1], req_op2};
  assign w_fast_full = $signed(w_x1) * $signed(w_x2);
`endif

  function automatic logic [XLEN-1:0] mul_final(input logic [2*XLEN-1:0] p,
                                                input logic neg, input logic [2:0] op);
    logic [2*XLEN-1:0] v;
    v = neg ? -p : p;
    return (op == 3'd0) ? v[XLEN-1:0] : v[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_final(input logic [2*XLEN-1:0] a,
                                                input logic neg_q, input logic neg_r,
                                                input logic [2:0] op);
    logic [XLEN-1:0] q, r;
    q = a[XLEN-1:0];
    r = a[2*XLEN-1:XLEN];
    if (op[1]) return neg_r ? -r : r;
    return neg_q ? -q : q;
  endfunction

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_acc_nxt        = r_acc;
    w_op2_nxt        = r_op2;
    w_op_nxt         = r_op;
    w_neg_q_nxt      = r_neg_q;
    w_neg_r_nxt      = r_neg_r;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_op_nxt    = req_op;
          w_op2_nxt   = w_mag2;
          w_acc_nxt   = {{XLEN{1'b0}}, w_mag1};
          w_neg_q_nxt = w_n1 ^ w_n2;
          w_neg_r_nxt = w_n1;
          w_cnt_nxt   = '0;
          if (!req_op[2]) begin
`ifdef MDU_FAST_MUL_EN
            w_state_nxt      = S_DONE;
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = (req_op == 3'd0) ? w_fast_full[XLEN-1:0]
                                                : w_fast_full[2*XLEN-1:XLEN];
`else
            w_state_nxt = S_MUL;
`endif
          end else if (w_div0) begin
            w_state_nxt      = S_DONE;
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = req_op[1] ? req_op1 : '1;
          end else if (w_ovf) begin
            w_state_nxt      = S_DONE;
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = req_op[1] ? '0 : req_op1;
          end else begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt = w_mul_acc;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt      = S_DONE;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = mul_final(w_mul_acc, r_neg_q, r_op);
        end
      end
      S_DIV: begin
        w_acc_nxt = w_div_acc;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt      = S_DONE;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = div_final(w_div_acc, r_neg_q, r_neg_r, r_op);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush overrides everything: no accept, no response, back to idle.
    if (flush) begin
      w_state_nxt      = S_IDLE;
      w_cnt_nxt        = '0;
      w_resp_valid_nxt = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_op2        <= '0;
      r_op         <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_acc        <= w_acc_nxt;
      r_op2        <= w_op2_nxt;
      r_op         <= w_op_nxt;
      r_neg_q      <= w_neg_q_nxt;
      r_neg_r      <= w_neg_r_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
    end
  end

  // A flush arriving in the DONE cycle still kills the strobe.
  assign resp_valid = r_resp_valid & ~flush;
  assign resp_data  = r_resp_data;
  assign busy       = req_valid & ~resp_valid;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=32): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_op1, req_op2;
  logic        flush;
  logic        busy, resp_valid;
  logic [31:0] resp_data;

  int n_vec = 0;
  int n_err = 0;

  ex_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .flush(flush),
    .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result straight from the RISC-V M-extension definitions.
  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from accept to the response strobe.
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op < 3'd4) begin
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request at a negedge, follow it to the response, then idle one cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          cyc, busy_cnt, exp_lat;
    bit          seen;
    logic [31:0] exp_d;
    exp_d   = ref_data(op, a, b);
    exp_lat = ref_lat(op, a, b);
    req_valid = 1'b1;
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    #1;
    chk("busy_accept", 64'(busy), 64'd1);
    cyc = 0; busy_cnt = 1; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) seen = 1;
      else begin
        if (busy) busy_cnt++;
        req_op1 = $urandom;
        req_op2 = $urandom;
      end
    end
    chk($sformatf("lat op%0d", op), 64'(cyc), 64'(exp_lat));
    chk($sformatf("data op%0d %h,%h", op, a, b), 64'(resp_data), 64'(exp_d));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
    chk("busy_done", 64'(busy), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pulse_end", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_op1 = '0; req_op2 = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, -32'd7, 32'd2);
    run_op(3'd6, -32'd7, 32'd2);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000);

    // Flush a DIVU ten cycles after accept; a MUL follows on the next cycle.
    req_valid = 1'b1; req_op = 3'd5; req_op1 = 32'd1000; req_op2 = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(resp_valid), 64'd0);
    run_op(3'd0, 32'd3, 32'd4);

    // Flush coinciding with the DONE cycle suppresses the strobe.
    req_valid = 1'b1; req_op = 3'd5; req_op1 = 32'd9; req_op2 = 32'd0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_done", 64'(resp_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_after", 64'(resp_valid), 64'd0);

    // Reset in the middle of a multiply.
    req_valid = 1'b1; req_op = 3'd0; req_op1 = 32'd11; req_op2 = 32'd13;
    repeat (5) @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", 64'(resp_data), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) chk("midrst_stray", 64'(resp_valid), 64'd0);
    end
    run_op(3'd0, 32'd11, 32'd13);

    for (int i = 0; i < 120; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_op(op, pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
